// File: rtl/rat_io_hub_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rat_io_hub_if : RAT MCU port-mapped I/O bus (ID, write data, strobe, read) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rat_io_hub_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] in_port;

  modport master (output port_id, output out_port, output io_strb, input in_port);
  modport slave  (input port_id, input out_port, input io_strb, output in_port);
endinterface
`default_nettype wire

// File: rtl/rat_io_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rat_io_hub : synced input bank, strobed output bank, 8-source edge IRQ    |
// | controller. Optional macro IO_READBACK_EN enables output-register reads.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rat_io_hub #(
  parameter int         N_IN        = 8,
  parameter int         N_OUT       = 4,
  parameter logic [7:0] IN_BASE     = 8'h90,
  parameter logic [7:0] OUT_BASE    = 8'h40,
  parameter logic [7:0] IRQ_STAT_ID = 8'hF0,
  parameter logic [7:0] IRQ_MASK_ID = 8'hF1,
  parameter logic [7:0] IRQ_ACK_ID  = 8'hF2
) (
  input  wire logic                clk,
  input  wire logic                reset,
  rat_io_hub_if.slave              bus,
  input  wire logic [8*N_IN-1:0]   ext_in,
  output logic      [8*N_OUT-1:0]  out_regs,
  output logic      [N_OUT-1:0]    out_wr,
  input  wire logic [7:0]          irq_src,
  output logic                     interrupt
);

  localparam int c_IN_LO  = int'(IN_BASE);
  localparam int c_IN_HI  = int'(IN_BASE) + N_IN - 1;
  localparam int c_OUT_LO = int'(OUT_BASE);
  localparam int c_OUT_HI = int'(OUT_BASE) + N_OUT - 1;
  localparam int c_STAT   = int'(IRQ_STAT_ID);
  localparam int c_MASK   = int'(IRQ_MASK_ID);
  localparam int c_ACK    = int'(IRQ_ACK_ID);

  localparam bit c_OVL_IO  = (c_IN_LO <= c_OUT_HI) && (c_OUT_LO <= c_IN_HI);
  localparam bit c_OVL_IN  = (c_STAT >= c_IN_LO && c_STAT <= c_IN_HI) ||
                             (c_MASK >= c_IN_LO && c_MASK <= c_IN_HI) ||
                             (c_ACK  >= c_IN_LO && c_ACK  <= c_IN_HI);
  localparam bit c_OVL_OUT = (c_STAT >= c_OUT_LO && c_STAT <= c_OUT_HI) ||
                             (c_MASK >= c_OUT_LO && c_MASK <= c_OUT_HI) ||
                             (c_ACK  >= c_OUT_LO && c_ACK  <= c_OUT_HI);
  localparam bit c_IRQ_DUP = (c_STAT == c_MASK) || (c_STAT == c_ACK) || (c_MASK == c_ACK);

  localparam logic [7:0] c_N_IN8  = 8'(N_IN);
  localparam logic [7:0] c_N_OUT8 = 8'(N_OUT);

  if (N_IN < 1 || N_IN > 16) begin : g_err_n_in
    $error("rat_io_hub: N_IN must be 1..16");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_err_n_out
    $error("rat_io_hub: N_OUT must be 1..16");
  end
  if (c_IN_HI > 255 || c_OUT_HI > 255) begin : g_err_wrap
    $error("rat_io_hub: ID range wraps past 8'hFF");
  end
  if (c_OVL_IO || c_OVL_IN || c_OVL_OUT || c_IRQ_DUP) begin : g_err_overlap
    $error("rat_io_hub: overlapping port ID ranges");
  end

  logic [8*N_IN-1:0]  r_in_s1;
  logic [8*N_IN-1:0]  r_in_s2;
  logic [8*N_OUT-1:0] r_out_regs;
  logic [N_OUT-1:0]   r_out_wr;
  logic [7:0]         r_irq_s1;
  logic [7:0]         r_irq_s2;
  logic [7:0]         r_irq_s3;
  logic [7:0]         r_pending;
  logic [7:0]         r_mask;
  logic               r_interrupt;

  logic [7:0] w_in_off;
  logic [7:0] w_out_off;
  logic       w_in_hit;
  logic       w_out_hit;
  logic [7:0] w_rise;
  logic [7:0] w_ack;
  logic [7:0] w_rd;

  assign w_in_off  = bus.port_id - IN_BASE;
  assign w_out_off = bus.port_id - OUT_BASE;
  assign w_in_hit  = (bus.port_id >= IN_BASE)  && (w_in_off  < c_N_IN8);
  assign w_out_hit = (bus.port_id >= OUT_BASE) && (w_out_off < c_N_OUT8);
  assign w_rise    = r_irq_s2 & ~r_irq_s3;
  assign w_ack     = (bus.io_strb && bus.port_id == IRQ_ACK_ID) ? bus.out_port : 8'h00;

  always_comb begin
    w_rd = 8'h00;
    if (w_in_hit) begin
      for (int k = 0; k < N_IN; k++) begin
        if (w_in_off == 8'(k)) w_rd = r_in_s2[8*k +: 8];
      end
    end
`ifdef IO_READBACK_EN
    else if (w_out_hit) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_out_off == 8'(k)) w_rd = r_out_regs[8*k +: 8];
      end
    end
`endif
    else if (bus.port_id == IRQ_STAT_ID) begin
      w_rd = r_pending;
    end else if (bus.port_id == IRQ_MASK_ID) begin
      w_rd = r_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_s1     <= '0;
      r_in_s2     <= '0;
      r_out_regs  <= '0;
      r_out_wr    <= '0;
      r_irq_s1    <= '0;
      r_irq_s2    <= '0;
      r_irq_s3    <= '0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_in_s1  <= ext_in;
      r_in_s2  <= r_in_s1;
      r_irq_s1 <= irq_src;
      r_irq_s2 <= r_irq_s1;
      r_irq_s3 <= r_irq_s2;
      r_out_wr <= '0;
      if (bus.io_strb && w_out_hit) begin
        for (int k = 0; k < N_OUT; k++) begin
          if (w_out_off == 8'(k)) begin
            r_out_regs[8*k +: 8] <= bus.out_port;
            r_out_wr[k]          <= 1'b1;
          end
        end
      end
      if (bus.io_strb && bus.port_id == IRQ_MASK_ID) r_mask <= bus.out_port;
      // New edges are ORed after the ack so a coincident set survives.
      r_pending   <= (r_pending & ~w_ack) | w_rise;
      r_interrupt <= |(r_pending & r_mask);
    end
  end

  assign bus.in_port = w_rd;
  assign out_regs    = r_out_regs;
  assign out_wr      = r_out_wr;
  assign interrupt   = r_interrupt;

endmodule
`default_nettype wire
